// File: rtl/mhsa_pkg.sv
// Shared constants and types for the MHSA datapath blocks.
// The weight-fetch FSM state type lives here so checkers and benches can decode it.
package mhsa_pkg;

  localparam int MHSA_WIDTH = 64;
  localparam int WV_WORDS   = 2048;

  typedef enum logic [1:0] {
    WV_IDLE  = 2'd0,
    WV_FETCH = 2'd1,
    WV_DRAIN = 2'd2,
    WV_DONE  = 2'd3
  } wv_state_e;

endpackage

// File: rtl/wv_fetch_if.sv
// Output word stream of the weight fetcher.
// Handshake: a word transfers on a rising edge where out_valid && out_ready; while out_valid=1 and
// out_ready=0 the master holds out_data/out_last; out_valid never depends on out_ready.
interface wv_fetch_if #(
  parameter int WIDTH = mhsa_pkg::MHSA_WIDTH
);
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/wv_fetch_fifo.sv
// Small output buffer holding fetched words together with their last flag.
// Depth need not be a power of two; pointers wrap explicitly.
module wv_fetch_fifo
  import mhsa_pkg::*;
#(
  parameter int WIDTH      = MHSA_WIDTH,
  parameter int FIFO_DEPTH = 2,
  localparam int CW        = $clog2(FIFO_DEPTH + 1),
  localparam int PW        = $clog2(FIFO_DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             push_last,
  output logic [CW-1:0]    count,
  wv_fetch_if.master       m
);

  logic [WIDTH:0]  mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            pop;

  always_comb begin
    pop      = (count_q != '0) && m.out_ready;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = (wr_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = (rd_ptr_q == PW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
    // Simultaneous push and pop leaves occupancy unchanged.
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {push_last, push_data};
  end

  // Storage is not reset, so the head is masked to zero whenever the buffer is empty.
  assign m.out_valid = (count_q != '0);
  assign m.out_data  = m.out_valid ? mem_q[rd_ptr_q][WIDTH-1:0] : '0;
  assign m.out_last  = m.out_valid ? mem_q[rd_ptr_q][WIDTH] : 1'b0;
  assign count       = count_q;

endmodule

// File: rtl/wv_fetch.sv
// Weight-vector burst fetcher: reads num_words consecutive words from a registered-output
// memory and streams them out with valid/ready, never holding more reads than buffer space.
module wv_fetch
  import mhsa_pkg::*;
#(
  parameter int WIDTH      = MHSA_WIDTH,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [31:0]      base_addr,
  input  logic [15:0]      num_words,
  output logic             busy,
  output logic             done,
  output logic [31:0]      mem_addr,
  output logic             mem_write_en,
  input  logic [WIDTH-1:0] mem_data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output wv_state_e        dbg_state
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  wv_state_e   state_q, state_d;
  logic [31:0] base_q, base_d;
  logic [15:0] num_q, num_d;
  logic [15:0] issued_q, issued_d;
  logic        inflight_q, inflight_d;
  logic        inflight_last_q, inflight_last_d;
  logic        issue, room, pop;
  logic [CW-1:0] fifo_count;

  wv_fetch_if #(.WIDTH(WIDTH)) stream_if ();

  assign stream_if.out_ready = out_ready;
  assign out_valid           = stream_if.out_valid;
  assign out_data            = stream_if.out_data;
  assign out_last            = stream_if.out_last;

  assign pop = stream_if.out_valid && out_ready;
  // A pop this cycle frees a slot in time for the read issued now, keeping 1 word/cycle.
  assign room = (32'(fifo_count) + 32'(inflight_q)) < (32'(FIFO_DEPTH) + 32'(pop));

  always_comb begin
    state_d         = state_q;
    base_d          = base_q;
    num_d           = num_q;
    issued_d        = issued_q;
    inflight_d      = 1'b0;
    inflight_last_d = 1'b0;
    issue           = 1'b0;
    case (state_q)
      WV_IDLE: begin
        if (start) begin
          base_d   = base_addr;
          num_d    = num_words;
          issued_d = '0;
          state_d  = (num_words == 16'd0) ? WV_DONE : WV_FETCH;
        end
      end
      WV_FETCH: begin
        if (issued_q == num_q) begin
          state_d = WV_DRAIN;
        end else if (room) begin
          issue           = 1'b1;
          issued_d        = issued_q + 16'd1;
          inflight_d      = 1'b1;
          inflight_last_d = (issued_q == num_q - 16'd1);
        end
      end
      WV_DRAIN: begin
        if (pop && stream_if.out_last) state_d = WV_DONE;
      end
      WV_DONE:  state_d = WV_IDLE;
      default:  state_d = WV_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= WV_IDLE;
      base_q          <= '0;
      num_q           <= '0;
      issued_q        <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      base_q          <= base_d;
      num_q           <= num_d;
      issued_q        <= issued_d;
      inflight_q      <= inflight_d;
      inflight_last_q <= inflight_last_d;
    end
  end

  // The memory returns data one cycle after the address; only cycles after an issue are captured.
  wv_fetch_fifo #(
    .WIDTH      (WIDTH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (inflight_q),
    .push_data (mem_data_out),
    .push_last (inflight_last_q),
    .count     (fifo_count),
    .m         (stream_if)
  );

  assign mem_addr     = base_q + {16'd0, issued_q};
  assign mem_write_en = 1'b0;
  assign busy         = (state_q != WV_IDLE);
  assign done         = (state_q == WV_DONE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_wv_fetch.sv
// Bench for wv_fetch: table of bursts plus hand sequences (stall, reset mid-burst, start while busy),
// scored against a queue of expected words built from address arithmetic.
module tb_wv_fetch;
  import mhsa_pkg::*;

  localparam int W        = 64;
  localparam int DEPTH    = 2;
  localparam int RM_ALWAYS = 0;
  localparam int RM_TOGGLE = 1;
  localparam int RM_RANDOM = 2;
  localparam int RM_HOLD0  = 3;

  typedef struct {
    logic [31:0] base;
    logic [15:0] num;
    int          mode;
    int          exp_words;
    int          exp_lasts;
  } vec_t;

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   base_addr = '0;
  logic [15:0]   num_words = '0;
  logic          busy, done, mem_write_en;
  logic [31:0]   mem_addr;
  logic [W-1:0]  mem_data_out;
  wv_state_e     dbg_state;

  wv_fetch_if #(.WIDTH(W)) sif ();

  always #5 clk = ~clk;

  wv_fetch #(.WIDTH(W), .FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .base_addr    (base_addr),
    .num_words    (num_words),
    .busy         (busy),
    .done         (done),
    .mem_addr     (mem_addr),
    .mem_write_en (mem_write_en),
    .mem_data_out (mem_data_out),
    .out_valid    (sif.out_valid),
    .out_ready    (sif.out_ready),
    .out_data     (sif.out_data),
    .out_last     (sif.out_last),
    .dbg_state    (dbg_state)
  );

  function automatic logic [W-1:0] word_of(input logic [31:0] a);
    return {~a ^ 32'h0F1E_2D3C, a};
  endfunction

  // Registered-output weight memory: content is a pure function of the address.
  always @(posedge clk) mem_data_out <= word_of(mem_addr);

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int ready_mode = RM_ALWAYS;
  int hs_count, last_count, done_count, issues, valid_seen, stab_err, max_out;
  int first_hs_cyc, last_hs_cyc, first_valid_cyc, first_issue_cyc, done_cyc, start_cyc;
  logic          prev_stall = 1'b0;
  logic [W:0]    prev_word;
  logic [W:0]    exp_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic reset_counters();
    hs_count = 0; last_count = 0; done_count = 0; issues = 0; valid_seen = 0;
    stab_err = 0; max_out = 0;
    first_hs_cyc = -1; last_hs_cyc = -1; first_valid_cyc = -1; first_issue_cyc = -1;
    done_cyc = -1; start_cyc = -1;
  endtask

  // Ready driver: changes just after each rising edge.
  initial begin
    sif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        RM_ALWAYS: sif.out_ready = 1'b1;
        RM_TOGGLE: sif.out_ready = ~sif.out_ready;
        RM_RANDOM: sif.out_ready = 1'($urandom_range(0, 1));
        default:   sif.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor + scoreboard, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && !(sif.out_valid && ({sif.out_last, sif.out_data} == prev_word))) stab_err++;
      if (sif.out_valid) begin
        valid_seen++;
        if (first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (dut.issue) begin
        issues++;
        if (first_issue_cyc < 0) first_issue_cyc = cyc;
      end
      if (done) begin
        done_count++;
        done_cyc = cyc;
      end
      if (sif.out_valid && sif.out_ready) begin
        if (exp_q.size() == 0) check("sb_unexpected_word", 0, 1);
        else check("sb_word", {sif.out_last, sif.out_data}, exp_q.pop_front());
        hs_count++;
        if (sif.out_last) last_count++;
        if (first_hs_cyc < 0) first_hs_cyc = cyc;
        last_hs_cyc = cyc;
      end
      if (issues - hs_count > max_out) max_out = issues - hs_count;
      prev_stall = sif.out_valid && !sif.out_ready;
      prev_word  = {sif.out_last, sif.out_data};
    end
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    if (chk) begin
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_out_valid", sif.out_valid, 0);
      check("rst_out_last", sif.out_last, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_out_data", sif.out_data, 0);
      check("rst_state", dbg_state, WV_IDLE);
    end
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic start_burst(input logic [31:0] b, input logic [15:0] n);
    @(posedge clk);
    #1;
    reset_counters();
    for (int i = 0; i < int'(n); i++)
      exp_q.push_back({(i == int'(n) - 1), word_of(b + 32'(i))});
    start     = 1'b1;
    base_addr = b;
    num_words = n;
    start_cyc = cyc;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base_addr = $urandom;
    num_words = 16'($urandom);
  endtask

  task automatic finish_burst(input int n, input int exp_words, input int exp_lasts,
                              input bit full_rate, input int budget);
    int k;
    k = 0;
    while (done_count == 0 && k < budget) begin
      @(negedge clk);
      #1;
      k++;
    end
    if (done_count == 0) begin
      check("done_timeout", 0, 1);
      do_reset(1'b0);
      return;
    end
    repeat (3) @(negedge clk);
    #1;
    check("words_delivered", hs_count, exp_words);
    check("last_flags", last_count, exp_lasts);
    check("queue_drained", exp_q.size(), 0);
    check("done_pulses", done_count, 1);
    check("hold_stable", stab_err, 0);
    check("outstanding_le_depth", (max_out <= DEPTH), 1);
    check("idle_after", {busy, dbg_state}, {1'b0, WV_IDLE});
    if (n == 0) begin
      check("zero_done_lat", done_cyc - start_cyc, 1);
      check("zero_no_reads", issues, 0);
      check("zero_no_valid", valid_seen, 0);
    end else begin
      check("done_after_last", done_cyc - last_hs_cyc, 1);
      if (full_rate) begin
        check("throughput", last_hs_cyc - first_hs_cyc, n - 1);
        check("first_valid_lat", first_valid_cyc - first_issue_cyc, 2);
      end
    end
  endtask

  // ---------------- test ----------------
  vec_t vecs[8];
  logic [W:0] held;
  int k;

  initial begin
    vecs[0] = '{32'h0000_0000, 16'd16, RM_ALWAYS, 16, 1};
    vecs[1] = '{32'h0000_0000, 16'd16, RM_TOGGLE, 16, 1};
    vecs[2] = '{32'h0000_0000, 16'd0,  RM_ALWAYS, 0,  0};
    vecs[3] = '{32'hFFFF_FFFC, 16'd6,  RM_RANDOM, 6,  1};
    vecs[4] = '{32'h0000_0064, 16'd1,  RM_ALWAYS, 1,  1};
    vecs[5] = '{32'h0000_0037, 16'd1,  RM_TOGGLE, 1,  1};
    vecs[6] = '{32'h0000_0007, 16'd33, RM_RANDOM, 33, 1};
    vecs[7] = '{32'h0000_03E8, 16'd0,  RM_RANDOM, 0,  0};
    reset_counters();

    // Reset values while held in reset, then quiet after release.
    repeat (3) @(negedge clk);
    #1;
    check("por_busy", busy, 0);
    check("por_out_valid", sif.out_valid, 0);
    check("por_mem_addr", mem_addr, 0);
    check("por_out_data", sif.out_data, 0);
    check("por_mem_write_en", mem_write_en, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("post_rst_quiet", {busy, done, sif.out_valid}, 3'b000);

    // Table of bursts.
    foreach (vecs[i]) begin
      ready_mode = vecs[i].mode;
      start_burst(vecs[i].base, vecs[i].num);
      finish_burst(int'(vecs[i].num), vecs[i].exp_words, vecs[i].exp_lasts,
                   vecs[i].mode == RM_ALWAYS, 20 * int'(vecs[i].num) + 100);
    end

    // Random bursts.
    for (int r = 0; r < 6; r++) begin
      logic [31:0] rb;
      logic [15:0] rn;
      rb = $urandom;
      rn = 16'($urandom_range(0, 40));
      ready_mode = RM_RANDOM;
      start_burst(rb, rn);
      finish_burst(int'(rn), int'(rn), (rn != 0) ? 1 : 0, 1'b0, 20 * int'(rn) + 100);
    end

    // Consumer stalls for 10 cycles mid-burst.
    ready_mode = RM_ALWAYS;
    start_burst(32'h0000_0200, 16'd16);
    k = 0;
    while (hs_count < 4 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("stall_reached_word4", (hs_count >= 4), 1);
    ready_mode = RM_HOLD0;
    @(posedge clk);
    #2;
    held = {sif.out_last, sif.out_data};
    repeat (10) @(posedge clk);
    #2;
    check("stall_valid_held", sif.out_valid, 1);
    check("stall_data_held", {sif.out_last, sif.out_data}, held);
    check("stall_buffered", issues - hs_count, DEPTH);
    ready_mode = RM_ALWAYS;
    finish_burst(16, 16, 1, 1'b0, 500);
    check("stall_word_mem_write_en", mem_write_en, 0);

    // Reset at word 5 of a full-size burst, then restart at the top of the weight array.
    ready_mode = RM_ALWAYS;
    start_burst(32'h0000_0000, 16'(WV_WORDS));
    k = 0;
    while (hs_count < 5 && k < 200) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("midburst_reached_word5", (hs_count >= 5), 1);
    do_reset(1'b1);
    repeat (3) @(negedge clk);
    #1;
    check("restart_quiet", {busy, sif.out_valid}, 2'b00);
    start_burst(32'(WV_WORDS - 8), 16'd8);
    finish_burst(8, 8, 1, 1'b1, 300);

    // Start pulses while busy must be ignored.
    ready_mode = RM_RANDOM;
    start_burst(32'h0000_0300, 16'd16);
    repeat (4) @(posedge clk);
    #1;
    start = 1'b1; base_addr = 32'hDEAD_0000; num_words = 16'd3;
    @(posedge clk);
    #1;
    start = 1'b0;
    finish_burst(16, 16, 1, 1'b0, 500);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule
